spectrum_streamer: RTL and testbench
====================================

# spectrum_streamer

Transmit side of the FFT-to-formant stream. Captures one FFT frame of complex bins, converts each bin in a fixed window to power (re² + im²), and buffers the window in BRAM. Replays the window to `formant` as exactly `I` contiguous `fft_valid`/`fft_data` words. Holds off the next frame until `formant` pulses `formant_valid`, because `formant` has no ready signal and accepts a new frame only from its idle state.

## Interface
Parameters:
- `BIT_WIDTH`, 32: output word width; must be ≥ 2·`SAMPLE_WIDTH`.
- `SAMPLE_WIDTH`, 16: signed width of `bin_re`/`bin_im`.
- `I`, 160: bins per output frame.
- `FFT_SIZE`, 1024: bins per input frame.
- `BIN_OFFSET`, 1: first captured bin index (skips DC); `BIN_OFFSET + I` ≤ `FFT_SIZE`.

Ports:
- `clk_in`  in  1  sole clock.
- `rst_in`  in  1  reset, asynchronous, active-high.
- `bin_valid`  in  1  input bin qualifier; gaps allowed.
- `bin_re`  in  `SAMPLE_WIDTH`  signed real part.
- `bin_im`  in  `SAMPLE_WIDTH`  signed imaginary part.
- `bin_last`  in  1  marks the last bin of an FFT frame; sampled only with `bin_valid`.
- `formant_valid`  in  1  done pulse from `formant`.
- `fft_valid`  out  1  output word qualifier.
- `fft_data`  out  `BIT_WIDTH`  bin power, unsigned.
- `busy`  out  1  high in SEND and WAIT_DONE.
- `frames_dropped`  out  16  count of dropped frames; saturates at 0xFFFF.

## Operation
- **Bin index counter** `bin_idx`:
  - Advances on each `bin_valid`.
  - Returns to 0 after a bin with `bin_last`, or after index `FFT_SIZE-1`, whichever comes first.
  - Reset value 0.
- **Power**: `p = re*re + im*im`, computed signed, zero-extended to `BIT_WIDTH`. Max value 2^31 at (-32768, -32768). No saturation is needed.
- **WAIT_FRAME** (reset state): on `bin_valid` with `bin_idx == 0`, go to CAPTURE; that bin is processed as index 0.
- **CAPTURE**:
  - Bins with `BIN_OFFSET ≤ bin_idx < BIN_OFFSET+I` are written to BRAM address `bin_idx - BIN_OFFSET`.
  - On `bin_last`, the window is complete when `bin_idx ≥ BIN_OFFSET+I-1`. A complete window goes to SEND.
  - An incomplete window increments `frames_dropped` and returns to WAIT_FRAME.
- **SEND**: read addresses 0…I-1 on I consecutive cycles. After the last word leaves, go to WAIT_DONE.
- **WAIT_DONE**: on `formant_valid`, go to WAIT_FRAME.
- **`formant_valid`** is ignored in all other states.
- **Frame drops during SEND/WAIT_DONE**: any frame start (`bin_valid` with `bin_idx == 0`) in SEND or WAIT_DONE increments `frames_dropped`. Its bins are not written.
- **Simultaneous events**: `formant_valid` and a frame-start bin in the same WAIT_DONE cycle drop that frame. Capture begins at the next frame.

## Timing
- Power pipeline is 1 register stage; the BRAM write occurs the cycle after bin acceptance.
- SEND is entered the cycle after the accepted `bin_last`. Read address 0 is issued in that first SEND cycle.
- The pending write (address I-1 when `BIN_OFFSET+I == FFT_SIZE`) lands before address I-1 is read.
- BRAM read latency is 2 cycles (HIGH_PERFORMANCE). `fft_valid` rises 2 cycles after address 0 is issued and stays high for exactly I cycles, with no gaps.
- Word k of each output frame is the power of bin `BIN_OFFSET+k`.
- Worst-case `bin_last` to first `fft_valid`: 3 cycles.
- **Reset values**: `fft_valid` 0, `fft_data` 0, `busy` 0, `frames_dropped` 0, state WAIT_FRAME, `bin_idx` 0.
- **Reset mid-operation**:
  - Outputs drop asynchronously, and the read pipeline valid bits clear.
  - BRAM contents are not cleared and are never replayed without a fresh capture.

## Structure
- Shared package `spectrum_pkg`:
  - state enum {WAIT_FRAME, CAPTURE, SEND, WAIT_DONE};
  - the `frames_dropped` width constant;
  - the `BRAM_READ_LATENCY = 2` constant.
- Sub-module: one `xilinx_true_dual_port_read_first_1_clock_ram` instance, `RAM_WIDTH = BIT_WIDTH`, `RAM_DEPTH = I`, configured as:
  - port A: write;
  - port B: read;
  - `regceb = 1`.
- All other logic stays in this module:
  - power multiply;
  - bin counter;
  - FSM;
  - read-valid shift register.

## Test plan
Common setup: `I=160`, `FFT_SIZE=1024`, `BIN_OFFSET=1`.

- **Basic frame**: bin n has re=n, im=0, driven with random `bin_valid` gaps. Required: 160 contiguous `fft_valid` cycles, word 0 = 1, word 159 = 25600, `busy` high from SEND until `formant_valid`.
- **Extreme values**: all bins re=-32768, im=-32768. Required: every word = 0x8000_0000; bins re=32767, im=0 → 0x3FFF_0001.
- **Back-pressure**: two frames back to back, `formant_valid` withheld until the second frame ends. Required: one output frame, `frames_dropped` = 1, third frame captured after the pulse.
- **Short frame**: `bin_last` at `bin_idx` 100. Required: no `fft_valid`, `frames_dropped` = 1, next full frame streams normally.
- **Reset mid-SEND**: assert `rst_in` at output word 50. Required: `fft_valid` low without waiting for a clock edge, `frames_dropped` = 0; a following frame yields a full 160-word burst.
- **Full-width window**: `BIN_OFFSET=864`, so the window ends at bin 1023 (`bin_last`). Required: word 159 equals the power of bin 1023, and `bin_last` to first `fft_valid` ≤ 3 cycles.

Source files
------------

// File: rtl/spectrum_pkg.sv
// Shared types and constants for the FFT-to-formant transmit path.
package spectrum_pkg;

    // Top-level sequencing of one captured window.
    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        CAPTURE    = 2'd1,
        SEND       = 2'd2,
        WAIT_DONE  = 2'd3
    } state_t;

    // Width of the saturating dropped-frame counter.
    localparam int DROP_W = 16;

    // Cycles from issuing a BRAM read address to data on the output register.
    localparam int BRAM_READ_LATENCY = 2;

endpackage

// File: rtl/spectrum_streamer_if.sv
// Bin input stream, formant done pulse and power output stream.
//
// Handshake: neither stream has a ready. A bin is taken on every cycle
// bin_valid is high (bin_re/bin_im/bin_last qualified by it); a power word
// is delivered on every cycle fft_valid is high and the consumer must take
// it. formant_valid is a single-cycle done pulse from the consumer.
interface spectrum_streamer_if #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int BIT_WIDTH    = 32
) ();
    logic                           bin_valid;
    logic signed [SAMPLE_WIDTH-1:0] bin_re;
    logic signed [SAMPLE_WIDTH-1:0] bin_im;
    logic                           bin_last;
    logic                           formant_valid;
    logic                           fft_valid;
    logic [BIT_WIDTH-1:0]           fft_data;

    modport master (
        output bin_valid, bin_re, bin_im, bin_last, formant_valid,
        input  fft_valid, fft_data
    );

    modport slave (
        input  bin_valid, bin_re, bin_im, bin_last, formant_valid,
        output fft_valid, fft_data
    );
endinterface

// File: rtl/xilinx_true_dual_port_read_first_1_clock_ram.sv
// Single-clock true dual-port read-first block RAM with optional output
// register (HIGH_PERFORMANCE gives 2-cycle read latency).
module xilinx_true_dual_port_read_first_1_clock_ram #(
    parameter int    RAM_WIDTH       = 18,
    parameter int    RAM_DEPTH       = 1024,
    parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE"
) (
    input  logic [$clog2(RAM_DEPTH)-1:0] addra,
    input  logic [$clog2(RAM_DEPTH)-1:0] addrb,
    input  logic [RAM_WIDTH-1:0]         dina,
    input  logic [RAM_WIDTH-1:0]         dinb,
    input  logic                         clka,
    input  logic                         wea,
    input  logic                         web,
    input  logic                         ena,
    input  logic                         enb,
    input  logic                         rsta,
    input  logic                         rstb,
    input  logic                         regcea,
    input  logic                         regceb,
    output logic [RAM_WIDTH-1:0]         douta,
    output logic [RAM_WIDTH-1:0]         doutb
);
    logic [RAM_WIDTH-1:0] mem_q [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] ram_data_a_q;
    logic [RAM_WIDTH-1:0] ram_data_b_q;

    // Both ports: read the old contents, then write if enabled.
    always_ff @(posedge clka) begin
        if (ena) begin
            if (wea) mem_q[addra] <= dina;
            ram_data_a_q <= mem_q[addra];
        end
        if (enb) begin
            if (web) mem_q[addrb] <= dinb;
            ram_data_b_q <= mem_q[addrb];
        end
    end

    if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_no_out_reg
        assign douta = ram_data_a_q;
        assign doutb = ram_data_b_q;
    end else begin : g_out_reg
        logic [RAM_WIDTH-1:0] douta_q;
        logic [RAM_WIDTH-1:0] doutb_q;

        // Output registers with synchronous reset and clock enable.
        always_ff @(posedge clka) begin
            if (rsta)        douta_q <= '0;
            else if (regcea) douta_q <= ram_data_a_q;
            if (rstb)        doutb_q <= '0;
            else if (regceb) doutb_q <= ram_data_b_q;
        end

        assign douta = douta_q;
        assign doutb = doutb_q;
    end
endmodule

// File: rtl/spectrum_streamer.sv
// Captures a window of FFT bins as power values into BRAM and replays it as
// one contiguous burst to formant, holding off new frames until formant
// reports done.
module spectrum_streamer
    import spectrum_pkg::*;
#(
    parameter int BIT_WIDTH    = 32,
    parameter int SAMPLE_WIDTH = 16,
    parameter int I            = 160,
    parameter int FFT_SIZE     = 1024,
    parameter int BIN_OFFSET   = 1
) (
    input  logic              clk_in,
    input  logic              rst_in,
    spectrum_streamer_if.slave bus,
    output logic              busy,
    output logic [DROP_W-1:0] frames_dropped,
    output state_t            dbg_state_o
);
    localparam int PW     = 2 * SAMPLE_WIDTH;
    localparam int IDX_W  = $clog2(FFT_SIZE);
    localparam int ADDR_W = $clog2(I);
    localparam int CNT_W  = $clog2(I + BRAM_READ_LATENCY);
    localparam int LAT    = BRAM_READ_LATENCY;

    localparam logic [31:0]      WIN_LO   = 32'(BIN_OFFSET);
    localparam logic [31:0]      WIN_HI   = 32'(BIN_OFFSET + I - 1);
    localparam logic [31:0]      IDX_LAST = 32'(FFT_SIZE - 1);
    localparam logic [CNT_W-1:0] LAST_RD  = CNT_W'(I - 1);
    localparam logic [CNT_W-1:0] SEND_END = CNT_W'(I - 1 + LAT);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    bin_idx_q, bin_idx_d;
    logic [DROP_W-1:0]   drop_q;
    logic [CNT_W-1:0]    send_cnt_q, send_cnt_d;
    logic [LAT-1:0]      rd_vld_q;
    logic                wr_en_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [BIT_WIDTH-1:0] pow_q;

    logic [31:0]          idx32;
    logic                 frame_start, frame_end, in_window;
    logic                 take_bin, drop_inc, rd_en;
    logic signed [PW-1:0] re_ext, im_ext, re_sq, im_sq;
    logic [PW-1:0]        pow_sum;
    logic [BIT_WIDTH-1:0] pow_w;
    logic [BIT_WIDTH-1:0] ram_doutb;
    logic [BIT_WIDTH-1:0] ram_douta_unused;
    logic                 fft_valid_w;

    assign idx32       = 32'(bin_idx_q);
    assign frame_start = bus.bin_valid && (bin_idx_q == '0);
    // Counter wrap at FFT_SIZE-1 ends a frame just like an explicit bin_last.
    assign frame_end   = bus.bin_last || (idx32 == IDX_LAST);
    assign in_window   = (idx32 >= WIN_LO) && (idx32 <= WIN_HI);

    // Power of the incoming bin; the sum of two squares fits unsigned in PW bits.
    always_comb begin
        re_ext  = PW'(bus.bin_re);
        im_ext  = PW'(bus.bin_im);
        re_sq   = re_ext * re_ext;
        im_sq   = im_ext * im_ext;
        pow_sum = re_sq + im_sq;
        pow_w   = BIT_WIDTH'(pow_sum);
    end

    // Bin index advances per valid bin and wraps at the end of each frame.
    always_comb begin
        bin_idx_d = bin_idx_q;
        if (bus.bin_valid) bin_idx_d = frame_end ? '0 : bin_idx_q + IDX_W'(1);
    end

    // Next state, read issue and drop accounting.
    always_comb begin
        state_d    = state_q;
        send_cnt_d = send_cnt_q;
        drop_inc   = 1'b0;
        take_bin   = 1'b0;
        rd_en      = 1'b0;
        case (state_q)
            WAIT_FRAME: begin
                if (frame_start) begin
                    take_bin = 1'b1;
                    state_d  = CAPTURE;
                end
            end
            CAPTURE: take_bin = bus.bin_valid;
            SEND: begin
                rd_en      = (send_cnt_q <= LAST_RD);
                send_cnt_d = send_cnt_q + CNT_W'(1);
                drop_inc   = frame_start;
                // Leave only once the last word is on the output.
                if (send_cnt_q == SEND_END) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                // A frame starting alongside formant_valid is still dropped.
                drop_inc = frame_start;
                if (bus.formant_valid) state_d = WAIT_FRAME;
            end
            default: state_d = WAIT_FRAME;
        endcase
        if (take_bin && frame_end) begin
            send_cnt_d = '0;
            if (idx32 >= WIN_HI) begin
                state_d = SEND;
            end else begin
                state_d  = WAIT_FRAME;
                drop_inc = 1'b1;
            end
        end
    end

    // FSM, counters and read-valid pipeline registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= WAIT_FRAME;
            bin_idx_q  <= '0;
            drop_q     <= '0;
            send_cnt_q <= '0;
            rd_vld_q   <= '0;
        end else begin
            state_q    <= state_d;
            bin_idx_q  <= bin_idx_d;
            send_cnt_q <= send_cnt_d;
            rd_vld_q   <= {rd_vld_q[LAT-2:0], rd_en};
            if (drop_inc && (drop_q != {DROP_W{1'b1}})) drop_q <= drop_q + DROP_W'(1);
        end
    end

    // One register stage between bin acceptance and the BRAM write.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            pow_q     <= '0;
        end else begin
            wr_en_q   <= take_bin && in_window;
            wr_addr_q <= ADDR_W'(idx32 - WIN_LO);
            if (bus.bin_valid) pow_q <= pow_w;
        end
    end

    xilinx_true_dual_port_read_first_1_clock_ram #(
        .RAM_WIDTH      (BIT_WIDTH),
        .RAM_DEPTH      (I),
        .RAM_PERFORMANCE("HIGH_PERFORMANCE")
    ) u_ram (
        .addra (wr_addr_q),
        .addrb (ADDR_W'(send_cnt_q)),
        .dina  (pow_q),
        .dinb  ('0),
        .clka  (clk_in),
        .wea   (wr_en_q),
        .web   (1'b0),
        .ena   (1'b1),
        .enb   (1'b1),
        .rsta  (rst_in),
        .rstb  (rst_in),
        .regcea(1'b1),
        .regceb(1'b1),
        .douta (ram_douta_unused),
        .doutb (ram_doutb)
    );

    // Data is gated by the valid bit so both drop together on reset.
    assign fft_valid_w    = rd_vld_q[LAT-1];
    assign bus.fft_valid  = fft_valid_w;
    assign bus.fft_data   = fft_valid_w ? ram_doutb : '0;
    assign busy           = (state_q == SEND) || (state_q == WAIT_DONE);
    assign frames_dropped = drop_q;
    assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_spectrum_streamer.sv
// Directed bench for spectrum_streamer: window offset 1 and window offset 864.
module tb_spectrum_streamer;
    import spectrum_pkg::*;

    localparam int SW = 16;
    localparam int BW = 32;
    localparam int NI = 160;
    localparam int M_RAMP  = 0;
    localparam int M_TABLE = 1;
    localparam int M_MIN   = 2;
    localparam int M_MAXRE = 3;

    typedef struct {
        logic signed [SW-1:0] re;
        logic signed [SW-1:0] im;
        logic [BW-1:0]        exp;
    } vec_t;

    vec_t vecs [9];

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    spectrum_streamer_if #(.SAMPLE_WIDTH(SW), .BIT_WIDTH(BW)) ba ();
    spectrum_streamer_if #(.SAMPLE_WIDTH(SW), .BIT_WIDTH(BW)) bb ();

    logic        busy_a, busy_b;
    logic [15:0] drop_a, drop_b;
    state_t      st_a, st_b;

    spectrum_streamer #(.BIT_WIDTH(BW), .SAMPLE_WIDTH(SW), .I(NI),
                        .FFT_SIZE(1024), .BIN_OFFSET(1)) dut_a (
        .clk_in(clk), .rst_in(rst), .bus(ba), .busy(busy_a),
        .frames_dropped(drop_a), .dbg_state_o(st_a));

    spectrum_streamer #(.BIT_WIDTH(BW), .SAMPLE_WIDTH(SW), .I(NI),
                        .FFT_SIZE(1024), .BIN_OFFSET(864)) dut_b (
        .clk_in(clk), .rst_in(rst), .bus(bb), .busy(busy_b),
        .frames_dropped(drop_b), .dbg_state_o(st_b));

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] exp_q_b[$];
    int run_a = 0, last_run_a = 0, run_b = 0, last_run_b = 0;
    logic [BW-1:0] first_word_a, last_word_a, first_word_b, last_word_b;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ba.fft_valid === 1'b1) begin
            if (run_a == 0) first_word_a = ba.fft_data;
            last_word_a = ba.fft_data;
            run_a++;
            check("busy_during_burst_a", 64'(busy_a), 64'(1));
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word_a: got %0h expected no word", ba.fft_data);
            end else begin
                check("word_a", 64'(ba.fft_data), 64'(exp_q.pop_front()));
            end
        end else if (run_a != 0) begin
            last_run_a = run_a;
            run_a = 0;
        end
    end

    always @(negedge clk) begin
        if (bb.fft_valid === 1'b1) begin
            if (run_b == 0) first_word_b = bb.fft_data;
            last_word_b = bb.fft_data;
            run_b++;
            if (exp_q_b.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word_b: got %0h expected no word", bb.fft_data);
            end else begin
                check("word_b", 64'(bb.fft_data), 64'(exp_q_b.pop_front()));
            end
        end else if (run_b != 0) begin
            last_run_b = run_b;
            run_b = 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bin(input bit sel, input logic v, input logic signed [SW-1:0] re,
                           input logic signed [SW-1:0] im, input logic last);
        if (sel) begin
            bb.bin_valid = v; bb.bin_re = re; bb.bin_im = im; bb.bin_last = last;
        end else begin
            ba.bin_valid = v; ba.bin_re = re; ba.bin_im = im; ba.bin_last = last;
        end
    endtask

    function automatic logic signed [SW-1:0] re_of(input int mode, input int n);
        case (mode)
            M_RAMP:  return SW'(n);
            M_TABLE: return vecs[(n == 0) ? 0 : (n - 1) % 9].re;
            M_MIN:   return 16'h8000;
            default: return 16'h7FFF;
        endcase
    endfunction

    function automatic logic signed [SW-1:0] im_of(input int mode, input int n);
        case (mode)
            M_RAMP:  return '0;
            M_TABLE: return vecs[(n == 0) ? 0 : (n - 1) % 9].im;
            M_MIN:   return 16'h8000;
            default: return '0;
        endcase
    endfunction

    function automatic logic [BW-1:0] word_of(input int mode, input int offset, input int k);
        case (mode)
            M_RAMP:  return BW'((offset + k) * (offset + k));
            M_TABLE: return vecs[k % 9].exp;
            M_MIN:   return 32'h8000_0000;
            default: return 32'h3FFF_0001;
        endcase
    endfunction

    task automatic push_frame(input bit sel, input int mode, input int offset);
        for (int k = 0; k < NI; k++) begin
            if (sel) exp_q_b.push_back(word_of(mode, offset, k));
            else     exp_q.push_back(word_of(mode, offset, k));
        end
    endtask

    task automatic drive_frame(input bit sel, input int mode, input int last_idx, input bit gaps);
        for (int n = 0; n <= last_idx; n++) begin
            if (gaps) begin
                set_bin(sel, 1'b0, '0, '0, 1'b0);
                repeat ($urandom_range(0, 2)) tick();
            end
            set_bin(sel, 1'b1, re_of(mode, n), im_of(mode, n), n == last_idx);
            tick();
        end
        set_bin(sel, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic pulse_formant(input bit sel);
        if (sel) bb.formant_valid = 1'b1; else ba.formant_valid = 1'b1;
        tick();
        if (sel) bb.formant_valid = 1'b0; else ba.formant_valid = 1'b0;
    endtask

    task automatic wait_burst(input bit sel, input string name);
        int c = 0;
        while (((sel ? exp_q_b.size() : exp_q.size()) != 0 ||
                (sel ? bb.fft_valid : ba.fft_valid)) && c < 2000) begin
            tick();
            c++;
        end
        check({name, "_burst_in_time"}, 64'(c < 2000), 64'(1));
        tick();
    endtask

    task automatic measure_latency(input bit sel, output int lat);
        lat = 1;
        while (!(sel ? bb.fft_valid : ba.fft_valid) && lat < 10) begin
            tick();
            lat++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int lat;
        int c;
        vecs[0] = '{re: 16'sd3,     im: 16'sd4,      exp: 32'd25};
        vecs[1] = '{re: -16'sd3,    im: -16'sd4,     exp: 32'd25};
        vecs[2] = '{re: 16'sd0,     im: 16'sd0,      exp: 32'd0};
        vecs[3] = '{re: -16'sd1,    im: -16'sd1,     exp: 32'd2};
        vecs[4] = '{re: 16'sd1000,  im: -16'sd2000,  exp: 32'd5000000};
        vecs[5] = '{re: 16'h8000,   im: 16'sd0,      exp: 32'h4000_0000};
        vecs[6] = '{re: 16'sd255,   im: 16'sd255,    exp: 32'd130050};
        vecs[7] = '{re: 16'h8000,   im: 16'h8000,    exp: 32'h8000_0000};
        vecs[8] = '{re: 16'sd32767, im: -16'sd32767, exp: 32'h7FFE_0002};

        set_bin(0, 1'b0, '0, '0, 1'b0);
        set_bin(1, 1'b0, '0, '0, 1'b0);
        ba.formant_valid = 1'b0;
        bb.formant_valid = 1'b0;

        // Reset values
        #1 rst = 1'b1;
        #1;
        check("reset_fft_valid", 64'(ba.fft_valid), 64'(0));
        check("reset_fft_data", 64'(ba.fft_data), 64'(0));
        check("reset_busy", 64'(busy_a), 64'(0));
        check("reset_dropped", 64'(drop_a), 64'(0));
        check("reset_state", 64'(st_a), 64'(WAIT_FRAME));
        tick();
        rst = 1'b0;
        tick();

        // Basic ramp frame with random gaps
        push_frame(0, M_RAMP, 1);
        drive_frame(0, M_RAMP, 1023, 1);
        check("busy_at_send_entry", 64'(busy_a), 64'(1));
        check("state_send", 64'(st_a), 64'(SEND));
        measure_latency(0, lat);
        check("latency_a", 64'(lat), 64'(3));
        wait_burst(0, "basic");
        check("basic_run_len", 64'(last_run_a), 64'(NI));
        check("basic_word0", 64'(first_word_a), 64'(1));
        check("basic_word159", 64'(last_word_a), 64'(25600));
        repeat (5) tick();
        check("busy_wait_done", 64'(busy_a), 64'(1));
        check("state_wait_done", 64'(st_a), 64'(WAIT_DONE));
        pulse_formant(0);
        check("busy_after_formant", 64'(busy_a), 64'(0));
        check("state_after_formant", 64'(st_a), 64'(WAIT_FRAME));

        // Table of hand-computed powers, then the extreme-value frames
        push_frame(0, M_TABLE, 1);
        drive_frame(0, M_TABLE, 1023, 0);
        wait_burst(0, "table");
        check("table_run_len", 64'(last_run_a), 64'(NI));
        pulse_formant(0);

        push_frame(0, M_MIN, 1);
        drive_frame(0, M_MIN, 1023, 0);
        wait_burst(0, "min");
        check("min_last_word", 64'(last_word_a), 64'h8000_0000);
        pulse_formant(0);

        push_frame(0, M_MAXRE, 1);
        drive_frame(0, M_MAXRE, 1023, 0);
        wait_burst(0, "maxre");
        check("maxre_first_word", 64'(first_word_a), 64'h3FFF_0001);
        pulse_formant(0);

        // Back-pressure: second frame arrives while the first is outstanding
        do_reset();
        push_frame(0, M_RAMP, 1);
        drive_frame(0, M_RAMP, 1023, 0);
        drive_frame(0, M_RAMP, 1023, 0);
        wait_burst(0, "bp_first");
        check("bp_run_len", 64'(last_run_a), 64'(NI));
        check("bp_dropped", 64'(drop_a), 64'(1));
        check("bp_busy_held", 64'(busy_a), 64'(1));
        pulse_formant(0);
        push_frame(0, M_TABLE, 1);
        drive_frame(0, M_TABLE, 1023, 0);
        wait_burst(0, "bp_third");
        check("bp_third_run_len", 64'(last_run_a), 64'(NI));
        check("bp_dropped_after", 64'(drop_a), 64'(1));
        pulse_formant(0);

        // Short frame ending at bin 100
        do_reset();
        drive_frame(0, M_RAMP, 100, 0);
        tick();
        check("short_dropped", 64'(drop_a), 64'(1));
        check("short_busy", 64'(busy_a), 64'(0));
        check("short_state", 64'(st_a), 64'(WAIT_FRAME));
        repeat (10) tick();
        push_frame(0, M_RAMP, 1);
        drive_frame(0, M_RAMP, 1023, 0);
        wait_burst(0, "after_short");
        check("after_short_run_len", 64'(last_run_a), 64'(NI));
        pulse_formant(0);

        // Reset in the middle of a burst
        push_frame(0, M_RAMP, 1);
        drive_frame(0, M_RAMP, 1023, 0);
        c = 0;
        while (run_a < 50 && c < 500) begin
            tick();
            c++;
        end
        check("word50_reached", 64'(c < 500), 64'(1));
        check("valid_before_reset", 64'(ba.fft_valid), 64'(1));
        rst = 1'b1;
        #1;
        check("async_valid_drop", 64'(ba.fft_valid), 64'(0));
        check("async_data_drop", 64'(ba.fft_data), 64'(0));
        check("async_busy_drop", 64'(busy_a), 64'(0));
        check("reset_mid_dropped", 64'(drop_a), 64'(0));
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
        repeat (10) tick();
        check("no_replay_state", 64'(st_a), 64'(WAIT_FRAME));
        push_frame(0, M_RAMP, 1);
        drive_frame(0, M_RAMP, 1023, 0);
        wait_burst(0, "after_reset");
        check("after_reset_run_len", 64'(last_run_a), 64'(NI));
        pulse_formant(0);

        // Window ending on the last bin of the FFT frame
        push_frame(1, M_RAMP, 864);
        drive_frame(1, M_RAMP, 1023, 0);
        measure_latency(1, lat);
        check("latency_b_le_3", 64'(lat <= 3), 64'(1));
        wait_burst(1, "full_window");
        check("full_run_len", 64'(last_run_b), 64'(NI));
        check("full_word0", 64'(first_word_b), 64'(746496));
        check("full_word159", 64'(last_word_b), 64'(1046529));
        check("full_dropped", 64'(drop_b), 64'(0));
        pulse_formant(1);
        check("full_state_after", 64'(st_b), 64'(WAIT_FRAME));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
